mult32x32_arbiter: RTL
======================

Name: mult32x32_arbiter

Overview:
Shares one mult32x32 multiplier (FSM plus 8x16 partial-product datapath) between NUM_REQ requesters. It picks a requester by round-robin, latches that requester's operands, pulses the multiplier start and watches its busy flag. When the multiplier finishes, it captures the 64-bit product and returns it with the requester ID. A watchdog reports an error if the multiplier does not respond.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
ID_W, $clog2(NUM_REQ) (minimum 1), width of rsp_id
TIMEOUT, 16, maximum cycles from START entry to busy falling; must be greater than 10

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
req  input  NUM_REQ  per-requester request; held high until its gnt
req_a  input  NUM_REQ*32  operand A, slice i belongs to requester i
req_b  input  NUM_REQ*32  operand B, slice i belongs to requester i
gnt  output  NUM_REQ  one-hot, one-cycle pulse when operands are accepted
rsp_valid  output  1  one-cycle result strobe
rsp_id  output  ID_W  requester the result belongs to
rsp_product  output  64  result; held until the next capture
rsp_err  output  1  qualifies rsp_valid: watchdog expired
busy  output  1  high in every state except IDLE
mul_start  output  1  start pulse to the multiplier
mul_a  output  32  latched operand A; stable from START until IDLE
mul_b  output  32  latched operand B; stable from START until IDLE
mul_busy  input  1  multiplier busy flag
mul_product  input  64  multiplier product register

Behaviour:
- Reset values: all outputs 0; state IDLE; RR pointer set so req[0] has highest priority; watchdog counter 0.
- States: IDLE, START, WAIT_HI, WAIT_LO, DONE.
- IDLE:
  - If any req is high, choose the first requester after the last granted one (round-robin).
  - In that same cycle: pulse gnt[i], load req_a/req_b slice i into the operand registers, store i as the ID, move to START.
  - With no request, stay in IDLE.
- START: mul_start=1 for exactly one cycle; clear the watchdog; move to WAIT_HI.
- WAIT_HI: wait for mul_busy=1, then move to WAIT_LO.
- WAIT_LO:
  - Wait for mul_busy=0.
  - In that cycle, register mul_product into rsp_product, set rsp_err=0, move to DONE.
- DONE:
  - rsp_valid=1 for one cycle, with rsp_id set to the stored ID.
  - Advance the RR pointer to the granted ID; move to IDLE.
- Watchdog:
  - Counts every cycle spent in WAIT_HI or WAIT_LO.
  - When it reaches TIMEOUT: rsp_product=0, rsp_err=1, move to DONE.
- Nominal latency (gnt at cycle T):
  - mul_start at T+1.
  - mul_busy high T+2..T+9.
  - Capture at T+10, rsp_valid at T+11.
  - Next gnt no earlier than T+12.
- Requests during a transaction are only evaluated in IDLE; no queuing.
- A requester that keeps req high after its gnt is treated as issuing a new request. Round-robin then serves every other active requester before it again.
- Dropping req before gnt is a protocol violation; no behaviour is guaranteed.
- Reset mid-operation: immediate return to IDLE with outputs 0; no rsp_valid for the aborted operation. The multiplier shares the same reset.
- Operand and ID registers do not change outside the IDLE-to-START transition.

Decomposition:
- Package mult32x32_arb_pkg:
  - state enum type;
  - constant MUL_BUSY_CYCLES=8;
  - constant MUL_START_TO_DONE=10 (cycles from gnt to capture).
- Sub-module mult32x32_rr_pick:
  - combinational round-robin chooser;
  - inputs: req vector, pointer;
  - outputs: one-hot grant, encoded ID, any-request flag.

Test Plan:
1. Single request, a=0xFFFFFFFF, b=0xFFFFFFFF, on req[0] at cycle T → gnt[0] at T, mul_start at T+1, rsp_valid at T+11 with rsp_product=0xFFFFFFFE00000001, rsp_id=0, rsp_err=0.
2. req[0] and req[1] both held high continuously from reset → grants in order 0,1,0,1; rsp_id follows the same order; gnt pulses 12 cycles apart.
3. Edge operands:
   - a=0, b=0x12345678 → product 0;
   - a=3, b=5 → 15;
   - a=0x80000000, b=2 → 0x0000000100000000.
4. Multiplier stub with mul_busy tied to 0 → rsp_valid with rsp_err=1 and rsp_product=0, TIMEOUT+1 cycles after START; the next request is then served normally.
5. reset asserted during WAIT_LO → all outputs 0 that cycle and no rsp_valid; after reset, a request on req[1] (3x7) returns 21 with rsp_id=1.
6. req[1] raised while busy=1 → no gnt until IDLE; gnt[1] in the cycle after DONE; mul_a/mul_b unchanged throughout the running operation.

Source files
------------

// File: rtl/mult32x32_arb_pkg.sv
// rtl/mult32x32_arb_pkg.sv - shared types and constants for the mult32x32 arbiter
// Purpose: FSM state type, nominal multiplier timing and the ID width helper.
// Ports: none (package).
package mult32x32_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_HI,
        ST_WAIT_LO,
        ST_DONE
    } arb_state_e;

    // Nominal multiplier behaviour: busy for 8 cycles, product captured 10
    // cycles after the grant.
    localparam int MUL_BUSY_CYCLES   = 8;
    localparam int MUL_START_TO_DONE = 10;

    // Requester ID width; a single-bit ID is kept even for degenerate sizes.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult32x32_arbiter_if.sv
// rtl/mult32x32_arbiter_if.sv - requester and multiplier bundle of the arbiter
// Purpose: groups the requester handshake, the result strobe and the
// multiplier control/status signals.
// Modports: slave = arbiter side, master = requesters plus multiplier side.
interface mult32x32_arbiter_if
    import mult32x32_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = id_width(NUM_REQ)
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [NUM_REQ-1:0]    gnt;
    logic                  rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic [63:0]           rsp_product;
    logic                  rsp_err;
    logic                  busy;
    logic                  mul_start;
    logic [31:0]           mul_a;
    logic [31:0]           mul_b;
    logic                  mul_busy;
    logic [63:0]           mul_product;

    modport slave (
        input  req, req_a, req_b, mul_busy, mul_product,
        output gnt, rsp_valid, rsp_id, rsp_product, rsp_err, busy,
               mul_start, mul_a, mul_b
    );

    modport master (
        output req, req_a, req_b, mul_busy, mul_product,
        input  gnt, rsp_valid, rsp_id, rsp_product, rsp_err, busy,
               mul_start, mul_a, mul_b
    );

endinterface

// File: rtl/mult32x32_rr_pick.sv
// rtl/mult32x32_rr_pick.sv - combinational round-robin chooser
// Purpose: picks the first active requester after the last granted one.
// Ports: req_i (request vector), ptr_i (last granted ID),
//        gnt_o (one-hot pick), id_o (encoded pick), any_o (any request).
module mult32x32_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    id_o,
    output logic               any_o
);
    logic [NUM_REQ-1:0] rot;
    logic               found;
    int                 pos;

    always_comb begin
        // rot[k] is requester (ptr + 1 + k) mod NUM_REQ, so bit 0 has priority.
        rot   = NUM_REQ'({req_i, req_i} >> (int'(ptr_i) + 1));
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                pos   = int'(ptr_i) + 1 + k;
            end
        end
        if (pos >= NUM_REQ) begin
            pos = pos - NUM_REQ;
        end
        any_o = found;
        id_o  = ID_W'(pos);
        gnt_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_o[i] = found && (pos == i);
        end
    end

endmodule

// File: rtl/mult32x32_arbiter.sv
// rtl/mult32x32_arbiter.sv - round-robin sharing of one 32x32 multiplier
// Purpose: grants one requester, latches its operands, starts the multiplier,
// waits for its busy pulse and returns the product (or a watchdog error).
// Ports: clk, reset (async, active-high), bus (slave modport: req/req_a/req_b
//        in, gnt/rsp_* out, mul_start/mul_a/mul_b out, mul_busy/mul_product in).
module mult32x32_arbiter
    import mult32x32_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = id_width(NUM_REQ),
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    mult32x32_arbiter_if.slave  bus
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    arb_state_e         state_q;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    id_q;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic [WD_W-1:0]    wd_q;
    logic               start_q;
    logic               valid_q;
    logic               err_q;
    logic [63:0]        product_q;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [ID_W-1:0]    pick_id;
    logic               pick_any;
    logic [31:0]        sel_a;
    logic [31:0]        sel_b;
    logic [WD_W-1:0]    wd_inc;
    logic               wd_expired;

    mult32x32_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .id_o    (pick_id),
        .any_o   (pick_any)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) begin
                sel_a = bus.req_a[i*32 +: 32];
                sel_b = bus.req_b[i*32 +: 32];
            end
        end
    end

    // Expiry counts the current wait cycle, so DONE follows TIMEOUT wait cycles.
    assign wd_inc     = wd_q + 1'b1;
    assign wd_expired = (wd_inc == WD_W'(TIMEOUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= ID_W'(NUM_REQ - 1);
            id_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            wd_q      <= '0;
            start_q   <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            product_q <= '0;
        end else begin
            start_q <= 1'b0;
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        a_q     <= sel_a;
                        b_q     <= sel_b;
                        id_q    <= pick_id;
                        start_q <= 1'b1;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    wd_q    <= '0;
                    state_q <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    wd_q <= wd_inc;
                    if (bus.mul_busy) begin
                        state_q <= ST_WAIT_LO;
                    end else if (wd_expired) begin
                        product_q <= '0;
                        err_q     <= 1'b1;
                        valid_q   <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end
                ST_WAIT_LO: begin
                    wd_q <= wd_inc;
                    // A completion in the expiry cycle still counts as on time.
                    if (!bus.mul_busy) begin
                        product_q <= bus.mul_product;
                        err_q     <= 1'b0;
                        valid_q   <= 1'b1;
                        state_q   <= ST_DONE;
                    end else if (wd_expired) begin
                        product_q <= '0;
                        err_q     <= 1'b1;
                        valid_q   <= 1'b1;
                        state_q   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ptr_q   <= id_q;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // The grant is decided combinationally in IDLE so the requester sees it in
    // the cycle its operands are taken; it is forced low while in reset.
    assign bus.gnt         = (state_q == ST_IDLE && !reset) ? pick_gnt : '0;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.mul_start   = start_q;
    assign bus.mul_a       = a_q;
    assign bus.mul_b       = b_q;
    assign bus.rsp_valid   = valid_q;
    assign bus.rsp_id      = id_q;
    assign bus.rsp_product = product_q;
    assign bus.rsp_err     = err_q;

endmodule
